shared_wire_arb: RTL
====================

SHARED_WIRE_ARB -- requirements
Module: shared_wire_arb

Interface
REQ-001 Parameter NREQ, default 4, SHALL set the number of requesters (2..8).
REQ-002 Parameter SIZE, default 4, SHALL set shared-word width as [SIZE-2:0] (SIZE-1 bits); localparam SIZEDEC = SIZE-2.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 req  input  NREQ  per-requester level request; held until granted.
REQ-006 wdata  input  NREQ*(SIZE-1)  requester i word at [i*(SIZE-1) +: SIZE-1].
REQ-007 gnt  output  NREQ  one-hot grant, at most one bit set.
REQ-008 busy  output  1  high whenever FSM is not IDLE.
REQ-009 shared_q  output  SIZE-1  shared register value.
REQ-010 conflict_cnt  output  8  saturating count of contended arbitrations (see Configuration).

Function
REQ-011 FSM SHALL have states IDLE, ARB, DRIVE, with transitions IDLE->ARB when |req, ARB->DRIVE unconditionally, DRIVE->IDLE unconditionally.
REQ-012 In ARB, winner SHALL be the first set req bit at or after rr_ptr, scanning upward modulo NREQ; winner index SHALL be registered.
REQ-013 gnt SHALL be asserted for exactly the DRIVE cycle, on the registered winner only.
REQ-014 At the end of DRIVE, shared_q SHALL load the winner's wdata slice sampled in DRIVE, and rr_ptr SHALL become (winner+1) mod NREQ.
REQ-015 Latency: req rising in cycle t with FSM IDLE -> gnt in t+2 -> shared_q new value visible t+3.
REQ-016 If the winner's req drops in ARB, the DRIVE cycle SHALL still occur and still load wdata (no abort).
REQ-017 req changes during ARB/DRIVE SHALL NOT alter the registered winner.
REQ-018 Back-to-back: if |req in DRIVE's following IDLE cycle, a new ARB SHALL start; minimum grant spacing 3 cycles.
REQ-019 shared_q SHALL hold its value when not in DRIVE; there SHALL be exactly one driver of shared_q (no initializer plus assign).
REQ-020 Wrap-around: rr_ptr = NREQ-1 with winner NREQ-1 SHALL return rr_ptr to 0.

Reset
REQ-021 On rst high at a clock edge: state=IDLE, gnt=0, busy=0, shared_q=0, rr_ptr=0, conflict_cnt=0.
REQ-022 rst asserted in ARB or DRIVE SHALL abort the transaction; shared_q SHALL NOT load that cycle.
REQ-023 rst SHALL take priority over all other events in the same cycle.

Configuration
REQ-024 Macro SHARED_WIRE_ARB_CONFLICT_EN defined: conflict_cnt SHALL increment by 1 (saturating at 255) on each ARB cycle where popcount(req) >= 2.
REQ-025 Macro undefined: conflict_cnt SHALL be constant 0 with no counter flops.

Structure
REQ-026 Package shared_wire_arb_pkg SHALL hold the FSM state enum (IDLE=2'd0, ARB=2'd1, DRIVE=2'd2) and constant CONFLICT_MAX = 8'd255.
REQ-027 Sub-module rr_pick (combinational round-robin selector: req, rr_ptr -> winner index, valid) SHALL be instantiated once.
REQ-028 An elaboration-time check SHALL error if SIZE < 2 or NREQ outside 2..8; zero or negative-MSB widths SHALL never elaborate.

Verification
REQ-029 Reset then req=4'b0001, wdata slice0=3'b101 -> gnt=0001 at t+2, shared_q=3'b101 at t+3, rr_ptr=1.
REQ-030 req=4'b1111 held, rr_ptr=0 -> grants in order 0001,0010,0100,1000,0001 spaced 3 cycles.
REQ-031 rr_ptr=3, req=4'b1001 -> gnt=1000, then rr_ptr=0 and next gnt=0001.
REQ-032 rst asserted during DRIVE with wdata=3'b111 -> shared_q stays 0, gnt=0 next cycle, state IDLE.
REQ-033 With SHARED_WIRE_ARB_CONFLICT_EN, 300 arbitrations under req=4'b0011 -> conflict_cnt=255; without macro -> 0.
REQ-034 SIZE=2, NREQ=2 -> shared_q 1 bit wide, functional; SIZE=1 -> elaboration error.

Source files
------------

// File: rtl/shared_wire_arb_pkg.sv
// Shared types and constants for the shared-wire arbiter.
// FSM state encoding and conflict counter ceiling.
package shared_wire_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARB   = 2'd1,
    DRIVE = 2'd2
  } state_e;

  localparam logic [7:0] CONFLICT_MAX = 8'd255;

  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/shared_wire_arb_rr_pick.sv
// Combinational round-robin selector: first set req bit at or after ptr_i.
// Ports: req_i (requests), ptr_i (start index), win_o (winner), valid_o.
module rr_pick
  import shared_wire_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [IW-1:0]   win_o,
  output logic            valid_o
);

  logic [IW:0] s;

  // Scan from the far end back toward ptr_i so the nearest hit wins.
  always_comb begin
    win_o   = ptr_i;
    valid_o = 1'b0;
    s       = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      s = {1'b0, ptr_i} + (IW+1)'(k);
      if (s >= (IW+1)'(NREQ)) begin
        s = s - (IW+1)'(NREQ);
      end
      if (req_i[s[IW-1:0]]) begin
        win_o   = s[IW-1:0];
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/shared_wire_arb.sv
// Round-robin arbiter granting one requester per 3-cycle slot to load a shared word.
// Ports: clk, rst (sync, active-high), req, wdata -> gnt, busy, shared_q, conflict_cnt.
// Option: define SHARED_WIRE_ARB_CONFLICT_EN to count contended arbitrations.
module shared_wire_arb
  import shared_wire_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int SIZE = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ*(SIZE-1)-1:0]   wdata,
  output logic [NREQ-1:0]            gnt,
  output logic                       busy,
  output logic [SIZE-2:0]            shared_q,
  output logic [7:0]                 conflict_cnt
);

  localparam int SIZEDEC = SIZE - 2;
  localparam int W       = SIZEDEC + 1;
  localparam int IW      = idx_w(NREQ);

  if (SIZE < 2 || NREQ < 2 || NREQ > 8) begin : g_bad_cfg
    $error("shared_wire_arb: need SIZE>=2 and NREQ in 2..8");
  end

  state_e          state_q, state_d;
  logic [IW-1:0]   winner_q, winner_d;
  logic            wvalid_q, wvalid_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [W-1:0]    shared_d;
  logic [IW-1:0]   pick_win;
  logic            pick_valid;
  logic [IW-1:0]   ptr_inc;
  logic [IW:0]     inc_s;
  logic [W-1:0]    words [NREQ];

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req_i   (req),
    .ptr_i   (rr_ptr_q),
    .win_o   (pick_win),
    .valid_o (pick_valid)
  );

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      words[i] = wdata[i*W +: W];
    end
  end

  always_comb begin
    inc_s = {1'b0, winner_q} + (IW+1)'(1);
    if (inc_s >= (IW+1)'(NREQ)) begin
      inc_s = '0;
    end
    ptr_inc = inc_s[IW-1:0];
  end

  always_comb begin
    state_d  = state_q;
    winner_d = winner_q;
    wvalid_d = wvalid_q;
    rr_ptr_d = rr_ptr_q;
    shared_d = shared_q;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = ARB;
        end
      end
      ARB: begin
        winner_d = pick_win;
        wvalid_d = pick_valid;
        state_d  = DRIVE;
      end
      DRIVE: begin
        state_d = IDLE;
        if (wvalid_q) begin
          shared_d = words[winner_q];
          rr_ptr_d = ptr_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      winner_q <= '0;
      wvalid_q <= 1'b0;
      rr_ptr_q <= '0;
      shared_q <= '0;
    end else begin
      state_q  <= state_d;
      winner_q <= winner_d;
      wvalid_q <= wvalid_d;
      rr_ptr_q <= rr_ptr_d;
      shared_q <= shared_d;
    end
  end

  always_comb begin
    gnt = '0;
    if (state_q == DRIVE && wvalid_q) begin
      gnt[winner_q] = 1'b1;
    end
  end

  assign busy = (state_q != IDLE);

`ifdef SHARED_WIRE_ARB_CONFLICT_EN
  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ARB && $countones(req) >= 2 && cnt_q != CONFLICT_MAX) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign conflict_cnt = cnt_q;
`else
  assign conflict_cnt = '0;
`endif

endmodule
